// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage RV32I core.
// Tracks in-flight destination registers in a shadow pipeline (ex/mem/wb),
// decides whether the ID instruction stalls, flushes the front stages when a
// taken branch/jump resolves in MEM, produces registered EX operand forwarding
// selects and keeps saturating stall/flush performance counters.
//
// Build option: define HAZARD_FORWARDING_EN to enable operand forwarding
// (only load-use stalls). Without it the selects are tied to 0 and a full
// interlock stalls on any EX or MEM producer.
//
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   id_valid_i                     ID holds a real instruction
//   id_rs1_i/id_rs2_i              ID source register indices
//   id_rs1_used_i/id_rs2_used_i    ID instruction reads rs1/rs2
//   id_rd_i, id_rd_wren_i          ID destination and its write enable
//   id_is_load_i                   ID instruction is a load
//   mem_br_taken_i                 taken branch/jump resolved in MEM
//   pc_en_o, if_id_en_o            PC and IF/ID enables (combinational)
//   if_id_flush_o/id_ex_flush_o/ex_mem_flush_o  bubble inserts (combinational)
//   fwd_a_sel_o/fwd_b_sel_o        EX operand selects (registered)
//   stall_cnt_o/flush_cnt_o        saturating performance counters
module hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [4:0]       id_rd_i,
    input  logic             id_rd_wren_i,
    input  logic             id_is_load_i,
    input  logic             mem_br_taken_i,
    output logic             pc_en_o,
    output logic             if_id_en_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_flush_o,
    output logic [1:0]       fwd_a_sel_o,
    output logic [1:0]       fwd_b_sel_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int unsigned REG_W = 5;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             wren;
        logic             is_load;
    } shadow_t;

    shadow_t ex_q, mem_q, wb_q, id_entry;
    logic    hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;
    logic    flush, stall_raw, stall;
    logic    wb_unused;

    // Producer entry would supply the source register being read.
    function automatic logic src_hit(shadow_t e, logic [REG_W-1:0] rs, logic used);
        return e.valid && e.wren && (e.rd != REG_W'(0)) && (e.rd == rs) && used;
    endfunction

    assign id_entry = '{valid: id_valid_i, rd: id_rd_i, wren: id_rd_wren_i,
                        is_load: id_is_load_i};

    assign hit_ex_a  = src_hit(ex_q,  id_rs1_i, id_rs1_used_i);
    assign hit_ex_b  = src_hit(ex_q,  id_rs2_i, id_rs2_used_i);
    assign hit_mem_a = src_hit(mem_q, id_rs1_i, id_rs1_used_i);
    assign hit_mem_b = src_hit(mem_q, id_rs2_i, id_rs2_used_i);

    // WB producers never hazard (regfile write-through); entry kept for tracking only.
    assign wb_unused = ^wb_q;

`ifdef HAZARD_FORWARDING_EN
    assign stall_raw = ex_q.is_load && (hit_ex_a || hit_ex_b);
`else
    assign stall_raw = hit_ex_a || hit_ex_b || hit_mem_a || hit_mem_b;
`endif

    assign flush = mem_br_taken_i;
    assign stall = stall_raw && !flush;

    // Stage enables and bubble inserts; flush overrides stall.
    always_comb begin
        pc_en_o        = 1'b1;
        if_id_en_o     = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        if (flush) begin
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
        end else if (stall) begin
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            id_ex_flush_o = 1'b1;
        end
    end

    // Shadow pipeline advance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= flush ? '0 : ex_q;
            ex_q  <= (flush || stall) ? '0 : id_entry;
        end
    end

`ifdef HAZARD_FORWARDING_EN
    logic       src_ok_a, src_ok_b;
    logic [1:0] fwd_a_d, fwd_b_d;

    assign src_ok_a = id_valid_i && id_rs1_used_i && (id_rs1_i != REG_W'(0));
    assign src_ok_b = id_valid_i && id_rs2_used_i && (id_rs2_i != REG_W'(0));

    // Youngest producer wins: EX/MEM ALUOut (1) before WB data (2).
    always_comb begin
        fwd_a_d = 2'd0;
        fwd_b_d = 2'd0;
        if (!flush && !stall) begin
            if (src_ok_a) begin
                if (hit_ex_a)       fwd_a_d = 2'd1;
                else if (hit_mem_a) fwd_a_d = 2'd2;
            end
            if (src_ok_b) begin
                if (hit_ex_b)       fwd_b_d = 2'd1;
                else if (hit_mem_b) fwd_b_d = 2'd2;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fwd_a_sel_o <= 2'd0;
            fwd_b_sel_o <= 2'd0;
        end else begin
            fwd_a_sel_o <= fwd_a_d;
            fwd_b_sel_o <= fwd_b_d;
        end
    end
`else
    assign fwd_a_sel_o = 2'd0;
    assign fwd_b_sel_o = 2'd0;
`endif

    // Saturating performance counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (flush && (flush_cnt_o != '1))
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (CNT_W = 4). Expectations follow the
// HAZARD_FORWARDING_EN setting of the build.
module tb_hazard_ctrl;

    localparam int unsigned CNT_W = 4;
`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             id_valid_i, id_rs1_used_i, id_rs2_used_i, id_rd_wren_i, id_is_load_i;
    logic [4:0]       id_rs1_i, id_rs2_i, id_rd_i;
    logic             mem_br_taken_i;
    logic             pc_en_o, if_id_en_o, if_id_flush_o, id_ex_flush_o, ex_mem_flush_o;
    logic [1:0]       fwd_a_sel_o, fwd_b_sel_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

    int n_vec = 0;
    int n_err = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .id_rd_i(id_rd_i), .id_rd_wren_i(id_rd_wren_i), .id_is_load_i(id_is_load_i),
        .mem_br_taken_i(mem_br_taken_i),
        .pc_en_o(pc_en_o), .if_id_en_o(if_id_en_o), .if_id_flush_o(if_id_flush_o),
        .id_ex_flush_o(id_ex_flush_o), .ex_mem_flush_o(ex_mem_flush_o),
        .fwd_a_sel_o(fwd_a_sel_o), .fwd_b_sel_o(fwd_b_sel_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; inputs are then driven and outputs sampled 1ns+ after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic we, input logic ld);
        id_valid_i = v; id_rs1_i = rs1; id_rs1_used_i = u1;
        id_rs2_i = rs2; id_rs2_used_i = u2;
        id_rd_i = rd; id_rd_wren_i = we; id_is_load_i = ld;
        #1;
    endtask

    task automatic drain();
        mem_br_taken_i = 1'b0;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        mem_br_taken_i = 1'b0;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #3;
        n_vec++; if (pc_en_o !== 1'b1) begin n_err++; $display("FAIL reset_pc_en got %b want 1", pc_en_o); end
        n_vec++; if (if_id_en_o !== 1'b1) begin n_err++; $display("FAIL reset_if_id_en got %b want 1", if_id_en_o); end
        n_vec++; if ({if_id_flush_o, id_ex_flush_o, ex_mem_flush_o} !== 3'b000) begin n_err++;
            $display("FAIL reset_flushes got %b want 000", {if_id_flush_o, id_ex_flush_o, ex_mem_flush_o}); end
        n_vec++; if ({fwd_a_sel_o, fwd_b_sel_o} !== 4'd0) begin n_err++;
            $display("FAIL reset_fwd got %0d/%0d want 0/0", fwd_a_sel_o, fwd_b_sel_o); end
        n_vec++; if (stall_cnt_o !== 4'd0 || flush_cnt_o !== 4'd0) begin n_err++;
            $display("FAIL reset_counters got %0d/%0d want 0/0", stall_cnt_o, flush_cnt_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    // Producer in ID, consumer follows after 'gap' filler instructions; checks
    // stall cycles, that the consumer then proceeds, and its EX select.
    task automatic run_pair(input string name, input logic ld, input int gap,
                            input logic [4:0] rs1, input logic [4:0] rs2,
                            input int n_stall, input logic [1:0] want_a, input logic [1:0] want_b);
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, ld);
        n_vec++; if (pc_en_o !== 1'b1) begin n_err++; $display("FAIL %s_producer_stall pc_en got %b want 1", name, pc_en_o); end
        tick();
        for (int g = 0; g < gap; g++) begin
            set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
            tick();
        end
        set_id(1'b1, rs1, 1'b1, rs2, 1'b1, 5'd6, 1'b1, 1'b0);
        for (int s = 0; s < n_stall; s++) begin
            n_vec++; if ({pc_en_o, if_id_en_o, id_ex_flush_o, if_id_flush_o} !== 4'b0010) begin n_err++;
                $display("FAIL %s_stall%0d pc_en,if_id_en,id_ex_fl,if_id_fl got %b want 0010",
                         name, s, {pc_en_o, if_id_en_o, id_ex_flush_o, if_id_flush_o}); end
            tick();
        end
        exp_stall += n_stall;
        n_vec++; if ({pc_en_o, if_id_en_o, id_ex_flush_o} !== 3'b110) begin n_err++;
            $display("FAIL %s_proceed got %b want 110", name, {pc_en_o, if_id_en_o, id_ex_flush_o}); end
        n_vec++; if (stall_cnt_o !== 4'(exp_stall)) begin n_err++;
            $display("FAIL %s_stall_cnt got %0d want %0d", name, stall_cnt_o, exp_stall); end
        tick();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        n_vec++; if (fwd_a_sel_o !== want_a || fwd_b_sel_o !== want_b) begin n_err++;
            $display("FAIL %s_fwd got %0d/%0d want %0d/%0d", name, fwd_a_sel_o, fwd_b_sel_o, want_a, want_b); end
        drain();
    endtask

    task automatic test_alu_adjacent();
        // add x5,x1,x2 ; add x6,x5,x0
        run_pair("alu_adj", 1'b0, 0, 5'd5, 5'd0, FWD ? 0 : 2, FWD ? 2'd1 : 2'd0, 2'd0);
    endtask

    task automatic test_alu_distance2();
        // add x5 ; nop ; add x6,x0,x5
        run_pair("alu_d2", 1'b0, 1, 5'd0, 5'd5, FWD ? 0 : 1, 2'd0, FWD ? 2'd2 : 2'd0);
    endtask

    task automatic test_load_use();
        // lw x5,0(x1) ; sub x6,x0,x5
        run_pair("load_use", 1'b1, 0, 5'd0, 5'd5, FWD ? 1 : 2, 2'd0, FWD ? 2'd2 : 2'd0);
    endtask

    task automatic test_no_hazard();
        // Producer writing x0 then consumer reading x0.
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
        n_vec++; if (pc_en_o !== 1'b1 || id_ex_flush_o !== 1'b0) begin n_err++;
            $display("FAIL x0_prod got pc_en=%b id_ex_fl=%b want 1/0", pc_en_o, id_ex_flush_o); end
        tick();
        // Load to x5, consumer names x5 in both slots but reads neither.
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1);
        n_vec++; if (fwd_a_sel_o !== 2'd0) begin n_err++; $display("FAIL x0_fwd got %0d want 0", fwd_a_sel_o); end
        tick();
        set_id(1'b1, 5'd5, 1'b0, 5'd5, 1'b0, 5'd6, 1'b1, 1'b0);
        n_vec++; if (pc_en_o !== 1'b1 || if_id_en_o !== 1'b1) begin n_err++;
            $display("FAIL unused_src got pc_en=%b if_id_en=%b want 1/1", pc_en_o, if_id_en_o); end
        tick();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        n_vec++; if (fwd_a_sel_o !== 2'd0 || fwd_b_sel_o !== 2'd0) begin n_err++;
            $display("FAIL unused_src_fwd got %0d/%0d want 0/0", fwd_a_sel_o, fwd_b_sel_o); end
        n_vec++; if (stall_cnt_o !== 4'(exp_stall)) begin n_err++;
            $display("FAIL unused_src_stall_cnt got %0d want %0d", stall_cnt_o, exp_stall); end
        drain();
    endtask

    task automatic test_flush_over_stall();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
        mem_br_taken_i = 1'b1;
        #1;
        n_vec++; if ({if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, pc_en_o, if_id_en_o} !== 5'b11111) begin n_err++;
            $display("FAIL flush_stall outs got %b want 11111",
                     {if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, pc_en_o, if_id_en_o}); end
        tick();
        exp_flush++;
        mem_br_taken_i = 1'b0;
        #1;
        n_vec++; if (pc_en_o !== 1'b1 || id_ex_flush_o !== 1'b0) begin n_err++;
            $display("FAIL flush_stall_next got pc_en=%b id_ex_fl=%b want 1/0", pc_en_o, id_ex_flush_o); end
        n_vec++; if (flush_cnt_o !== 4'(exp_flush)) begin n_err++;
            $display("FAIL flush_stall_fcnt got %0d want %0d", flush_cnt_o, exp_flush); end
        n_vec++; if (stall_cnt_o !== 4'(exp_stall)) begin n_err++;
            $display("FAIL flush_stall_scnt got %0d want %0d", stall_cnt_o, exp_stall); end
        drain();
    endtask

    task automatic test_back_to_back();
        mem_br_taken_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd7, 1'b1, 1'b0);
            n_vec++; if ({if_id_flush_o, id_ex_flush_o, ex_mem_flush_o} !== 3'b111) begin n_err++;
                $display("FAIL b2b_flush%0d got %b want 111", i, {if_id_flush_o, id_ex_flush_o, ex_mem_flush_o}); end
            tick();
            exp_flush++;
        end
        mem_br_taken_i = 1'b0;
        #1;
        n_vec++; if (flush_cnt_o !== 4'(exp_flush)) begin n_err++;
            $display("FAIL b2b_fcnt got %0d want %0d", flush_cnt_o, exp_flush); end
        n_vec++; if (if_id_flush_o !== 1'b0) begin n_err++; $display("FAIL b2b_release got %b want 0", if_id_flush_o); end
        drain();
    endtask

    task automatic test_saturation();
        int guard;
        for (int p = 0; p < 14; p++) begin
            set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1);
            tick();
            set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
            guard = 0;
            while (pc_en_o === 1'b0 && guard < 8) begin
                tick();
                guard++;
            end
            if (guard >= 8) begin
                n_vec++; n_err++;
                $display("FAIL sat_stall_timeout pair %0d stalled %0d cycles want <8", p, guard);
            end
            tick();
        end
        drain();
        n_vec++; if (stall_cnt_o !== 4'd15) begin n_err++; $display("FAIL sat_stall_cnt got %0d want 15", stall_cnt_o); end
    endtask

    task automatic test_reset_mid_stall();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
        n_vec++; if (pc_en_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_prestall got %b want 0", pc_en_o); end
        rst_ni = 1'b0;
        #1;
        n_vec++; if (pc_en_o !== 1'b1 || if_id_en_o !== 1'b1 || id_ex_flush_o !== 1'b0) begin n_err++;
            $display("FAIL mid_rst_release got pc_en=%b if_id_en=%b id_ex_fl=%b want 1/1/0",
                     pc_en_o, if_id_en_o, id_ex_flush_o); end
        n_vec++; if (stall_cnt_o !== 4'd0 || flush_cnt_o !== 4'd0) begin n_err++;
            $display("FAIL mid_rst_counters got %0d/%0d want 0/0", stall_cnt_o, flush_cnt_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        n_vec++; if (pc_en_o !== 1'b1) begin n_err++; $display("FAIL post_rst_nostall got %b want 1", pc_en_o); end
        drain();
    endtask

    initial begin
        test_reset();
        test_alu_adjacent();
        test_alu_distance2();
        test_load_use();
        test_no_hazard();
        test_flush_over_stall();
        test_back_to_back();
        test_saturation();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
